// File: rtl/keypad_pkg.sv
`default_nettype none
// =====================================================================
// keypad_pkg : shared sizes and snapshot helpers for the keypad scanner
// Rev 1.0
// =====================================================================
package keypad_pkg;

  localparam int KP_ROWS   = 4;
  localparam int KP_COLS   = 4;
  localparam int KP_KEYS   = 16;
  localparam int KP_CODE_W = 4;

  typedef enum logic [1:0] {
    PC_ZERO = 2'd0,
    PC_ONE  = 2'd1,
    PC_MANY = 2'd2
  } popcnt_e;

  function automatic popcnt_e popcount16(input logic [KP_KEYS-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < KP_KEYS; i++) begin
      if (v[i]) n++;
    end
    if (n == 0) return PC_ZERO;
    if (n == 1) return PC_ONE;
    return PC_MANY;
  endfunction

  // Snapshot bit index is col*4+row; the reported code is row*4+col.
  function automatic logic [KP_CODE_W-1:0] snap_to_code(input logic [KP_KEYS-1:0] v);
    logic [KP_CODE_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < KP_KEYS; i++) begin
      if (v[i]) idx = KP_CODE_W'(i);
    end
    return {idx[1:0], idx[3:2]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_if.sv
`default_nettype none
// =====================================================================
// keypad_if : keypad matrix lines and decoded key outputs
// Rev 1.0
// =====================================================================
interface keypad_if;
  import keypad_pkg::*;

  logic [KP_ROWS-1:0]   row_in;
  logic [KP_COLS-1:0]   col_out;
  logic [KP_CODE_W-1:0] key_code;
  logic                 key_valid;
  logic                 key_held;

  modport master (
    input  row_in,
    output col_out,
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    output row_in,
    input  col_out,
    input  key_code,
    input  key_valid,
    input  key_held
  );

endinterface
`default_nettype wire

// File: rtl/keypad_debounce.sv
`default_nettype none
// =====================================================================
// keypad_debounce : declares a 16-key snapshot stable after DEBOUNCE
//                   identical consecutive sweeps
// Rev 1.0
// =====================================================================
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE = 4
) (
  input  logic               sys_clk,
  input  logic               rst,
  input  logic               snap_done,
  input  logic [KP_KEYS-1:0] cur_snap,
  output logic [KP_KEYS-1:0] stable_snap,
  output logic               stable_upd
);

  localparam int                CNT_W    = $clog2(DEBOUNCE);
  localparam logic [CNT_W-1:0]  SAME_SAT = CNT_W'(DEBOUNCE - 1);

  logic [KP_KEYS-1:0] prev_snap;
  logic [CNT_W-1:0]   same_cnt;
  logic [CNT_W-1:0]   same_inc;
  logic               snap_eq;

  // The stable decision uses the incremented count so the snapshot that
  // completes the run is committed on the same sweep-end cycle.
  always_comb begin
    snap_eq    = (cur_snap == prev_snap);
    same_inc   = (same_cnt == SAME_SAT) ? SAME_SAT : same_cnt + CNT_W'(1);
    stable_upd = snap_done && snap_eq && (same_inc == SAME_SAT) &&
                 (cur_snap != stable_snap);
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      prev_snap   <= '0;
      same_cnt    <= '0;
      stable_snap <= '0;
    end else if (snap_done) begin
      same_cnt  <= snap_eq ? same_inc : '0;
      prev_snap <= cur_snap;
      if (stable_upd) begin
        stable_snap <= cur_snap;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// =====================================================================
// keypad_scanner : 4x4 matrix column scan with debounced single-press
//                  strobe and key code
// Rev 1.0
// =====================================================================
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 4
) (
  input  logic     sys_clk,
  input  logic     rst,
  keypad_if.master bus
);

  localparam int               DIV_W    = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [KP_ROWS-1:0]   row_meta;
  logic [KP_ROWS-1:0]   rows_s;
  logic [DIV_W-1:0]     div_cnt;
  logic [1:0]           col_idx;
  logic [KP_KEYS-1:0]   cur_snap;
  logic [KP_KEYS-1:0]   snap_full;
  logic [KP_KEYS-1:0]   stable_snap;
  logic                 stable_upd;
  logic                 slot_end;
  logic                 snap_done;
  logic                 press_ok;
  logic [KP_CODE_W-1:0] key_code;
  logic                 key_valid;

  // snap_full is cur_snap with the active column's rows overlaid, so on the
  // column-3 sample it is the complete sweep seen by the debouncer.
  always_comb begin
    slot_end  = (div_cnt == DIV_LAST);
    snap_done = slot_end && (col_idx == 2'd3);
    snap_full = cur_snap;
    snap_full[{col_idx, 2'b00} +: KP_ROWS] = ~rows_s;
    press_ok  = stable_upd &&
                (popcount16(snap_full) == PC_ONE) &&
                (popcount16(stable_snap) == PC_ZERO);
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      row_meta  <= '1;
      rows_s    <= '1;
      div_cnt   <= '0;
      col_idx   <= '0;
      cur_snap  <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
    end else begin
      row_meta  <= bus.row_in;
      rows_s    <= row_meta;
      key_valid <= 1'b0;
      if (slot_end) begin
        div_cnt  <= '0;
        col_idx  <= col_idx + 2'd1;
        cur_snap <= snap_full;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
      if (press_ok) begin
        key_valid <= 1'b1;
        key_code  <= snap_to_code(snap_full);
      end
    end
  end

  keypad_debounce #(
    .DEBOUNCE (DEBOUNCE)
  ) u_debounce (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .snap_done   (snap_done),
    .cur_snap    (snap_full),
    .stable_snap (stable_snap),
    .stable_upd  (stable_upd)
  );

  assign bus.col_out   = ~(4'b0001 << col_idx);
  assign bus.key_code  = key_code;
  assign bus.key_valid = key_valid;
  assign bus.key_held  = (popcount16(stable_snap) == PC_ONE);

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// =====================================================================
// tb_keypad_scanner : phase-table and corner-case bench with a keypad model
// Rev 1.0
// =====================================================================
module tb_keypad_scanner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] keys = 16'h0000;   // bit r*4+c = key (row r, col c) pressed
  logic [3:0]  row_drv;

  keypad_if kp();

  keypad_scanner #(
    .SCAN_DIV (4),
    .DEBOUNCE (3)
  ) dut (
    .sys_clk (clk),
    .rst     (rst),
    .bus     (kp)
  );

  always #5 clk = ~clk;

  always_comb begin
    row_drv = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && (kp.col_out[c] == 1'b0)) row_drv[r] = 1'b0;
      end
    end
  end
  assign kp.row_in = row_drv;

  typedef struct {
    logic [15:0] keys;
    int          sweeps;
    int          exp_strobes;
    int          exp_code;
    int          exp_held;
    int          exp_first;   // negedge index of first strobe in phase, -1 = don't care
  } phase_t;

  phase_t tbl [18];

  int tests = 0;
  int fails = 0;
  int n_since_rst;
  int phase_j;
  int strobes;
  int first_j;
  int last_code;
  int col_err;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_phase();
    phase_j   = 0;
    strobes   = 0;
    first_j   = -1;
    last_code = -1;
    col_err   = 0;
  endtask

  task automatic run_cycles(input int cyc);
    logic [3:0] exp_col;
    for (int i = 0; i < cyc; i++) begin
      @(negedge clk);
      n_since_rst++;
      phase_j++;
      exp_col = ~(4'b0001 << ((n_since_rst / 4) % 4));
      if (kp.col_out !== exp_col) col_err++;
      if (kp.key_valid === 1'b1) begin
        strobes++;
        last_code = int'(kp.key_code);
        if (first_j < 0) first_j = phase_j;
      end else if (kp.key_valid !== 1'b0) begin
        strobes += 100;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " col_out"},   int'(kp.col_out),   4'b1110);
    check({tag, " key_valid"}, int'(kp.key_valid), 0);
    check({tag, " key_held"},  int'(kp.key_held),  0);
    check({tag, " key_code"},  int'(kp.key_code),  0);
  endtask

  initial begin
    tbl[0]  = '{16'h0000, 20, 0,  0, 0, -1};
    tbl[1]  = '{16'h0200,  4, 1,  9, 1, 47};
    tbl[2]  = '{16'h0000,  2, 0,  0, 1, -1};
    tbl[3]  = '{16'h0000,  2, 0,  0, 0, -1};
    tbl[4]  = '{16'h8001,  4, 0,  0, 0, -1};
    tbl[5]  = '{16'h0001,  4, 0,  0, 1, -1};
    tbl[6]  = '{16'h0000,  4, 0,  0, 0, -1};
    tbl[7]  = '{16'h0080,  4, 1,  7, 1, 47};
    tbl[8]  = '{16'h0000,  4, 0,  0, 0, -1};
    tbl[9]  = '{16'h0080,  4, 1,  7, 1, 47};
    tbl[10] = '{16'h0000,  4, 0,  0, 0, -1};
    tbl[11] = '{16'h1000,  4, 1, 12, 1, 47};
    tbl[12] = '{16'h0008,  4, 0,  0, 1, -1};
    tbl[13] = '{16'h0000,  4, 0,  0, 0, -1};
    tbl[14] = '{16'h4000,  2, 0,  0, 0, -1};
    tbl[15] = '{16'h0000,  4, 0,  0, 0, -1};
    tbl[16] = '{16'h0008,  4, 1,  3, 1, 47};
    tbl[17] = '{16'h0000,  4, 0,  0, 0, -1};

    // Reset held for three cycles.
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    n_since_rst = 0;
    clear_phase();
    run_cycles(1);

    // Phases start one cycle after a sweep boundary so every sweep of the
    // phase samples the new key state in all four columns.
    for (int p = 0; p < 18; p++) begin
      keys = tbl[p].keys;
      clear_phase();
      run_cycles(16 * tbl[p].sweeps);
      check($sformatf("p%0d strobes", p), strobes, tbl[p].exp_strobes);
      check($sformatf("p%0d key_held", p), int'(kp.key_held), tbl[p].exp_held);
      check($sformatf("p%0d col_out seq errs", p), col_err, 0);
      if (tbl[p].exp_strobes > 0)
        check($sformatf("p%0d key_code", p), last_code, tbl[p].exp_code);
      if (tbl[p].exp_first >= 0)
        check($sformatf("p%0d strobe cycle", p), first_j, tbl[p].exp_first);
    end

    // Mid-scan reset while (0,2) is held and column 2 is active.
    keys = 16'h0004;
    clear_phase();
    run_cycles(64);
    check("midrst pre strobes", strobes, 1);
    check("midrst pre code", last_code, 2);
    run_cycles(9);
    check("midrst col2 active", int'(kp.col_out), 4'b1011);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b0;
    n_since_rst = 0;
    clear_phase();
    run_cycles(1);
    clear_phase();
    run_cycles(64);
    check("midrst strobes", strobes, 1);
    check("midrst code", last_code, 2);
    check("midrst strobe cycle", first_j, 47);
    check("midrst key_held", int'(kp.key_held), 1);
    check("midrst col_out seq errs", col_err, 0);

    keys = 16'h0000;
    clear_phase();
    run_cycles(64);
    check("release key_held", int'(kp.key_held), 0);

    // Bounce on (2,1): toggle every 10 cycles for 5 sweeps, then hold.
    clear_phase();
    for (int s = 0; s < 8; s++) begin
      keys = (s % 2 == 0) ? 16'h0200 : 16'h0000;
      run_cycles(10);
    end
    check("bounce quiet strobes", strobes, 0);
    keys = 16'h0200;
    run_cycles(64);
    check("bounce strobes", strobes, 1);
    check("bounce code", last_code, 9);
    check("bounce strobe cycle", first_j, 111);
    check("bounce key_held", int'(kp.key_held), 1);
    check("bounce col_out seq errs", col_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 matrix keypad by driving one column low at a time and sampling the rows. It debounces the full 16-key snapshot and emits a one-cycle strobe with a 4-bit key code for each clean single-key press. It is the input-side counterpart of the multiplexed seven-segment display path. Its `key_code`/`key_valid` outputs feed the game control logic that advances step counts and game status.

## Interface
Parameters:
- `SCAN_DIV`, default 50000: `sys_clk` cycles each column is held active; minimum 4.
- `DEBOUNCE`, default 4: consecutive identical full sweeps required before a snapshot becomes stable; minimum 2.

Ports:
- `sys_clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `row_in` in 4: keypad rows, active low, externally pulled up, asynchronous to `sys_clk`.
- `col_out` out 4: column drive, active low, exactly one bit low at any time.
- `key_code` out 4: code of the last accepted key, `row*4 + col`.
- `key_valid` out 1: one-cycle strobe; `key_code` is valid in the same cycle.
- `key_held` out 1: high while the stable snapshot has exactly one key pressed.

## Operation
- **Row synchronisation:** `row_in` passes through a 2-FF synchroniser. All logic uses the synchronised value `rows_s`.
- **Scan counter:**
  - `div_cnt` counts 0..SCAN_DIV-1.
  - `col_idx` counts 0..3 and advances when `div_cnt` = SCAN_DIV-1.
  - 3 wraps to 0.
  - `col_out` = ~(1 << `col_idx`).
- **Sampling:**
  - On the cycle where `div_cnt` = SCAN_DIV-1, `~rows_s` is written into `cur_snap[col_idx*4 +: 4]`.
  - Sampling at the end of the slot gives SCAN_DIV-1 cycles of settling plus synchroniser delay.
  - Bit index is `col*4+row`, as a 16-bit one-hot-per-key vector.
- **Sweep end:** the sample cycle with `col_idx` = 3.
  - Compare the completed `cur_snap` against `prev_snap`.
  - If equal, `same_cnt` saturates upward. Otherwise `same_cnt` is cleared to 0.
  - Then `prev_snap` <= `cur_snap`.
  - When `same_cnt` reaches DEBOUNCE-1, the snapshot is declared stable: `stable_snap` <= `cur_snap`. This happens only if it differs from `stable_snap`.
- **Press detection,** evaluated when `stable_snap` updates:
  - Accept the new stable value only if it has exactly one bit set and the old `stable_snap` was all zeros.
  - On acceptance: `key_code` <= index of that bit (`row*4+col`), and `key_valid` pulses for one cycle.
- **Ignored transitions (no strobe):**
  - Multi-key snapshots.
  - Going from one key directly to another without passing through all-released.
  - Releases.
- `key_held` = (`stable_snap` has exactly one bit set). It is combinational from a register.
- **Reset mid-scan:** all state returns to the reset values. A key already held at reset is reported once it has been stable for DEBOUNCE sweeps.

## Timing
- **Reset values:**
  - `col_out` = 4'b1110
  - `key_code` = 0, `key_valid` = 0, `key_held` = 0
  - `div_cnt`, `col_idx`, `same_cnt` = 0
  - `cur_snap`, `prev_snap`, `stable_snap` = 0
- **Sweep period:** 4*SCAN_DIV cycles.
- **Strobe timing:** `key_valid` is asserted on the cycle after the sweep-end sample that makes the snapshot stable (registered output).
- **Press latency:** from a press held steadily before a sweep starts, `key_valid` follows DEBOUNCE full sweeps later, plus 1 cycle.
- **Release latency:** DEBOUNCE sweeps to `key_held`=0. A new press is accepted only after that.
- **Bounce:** any single differing sweep restarts the DEBOUNCE count.
- **Simultaneous events:** on a sweep-end cycle, the `same_cnt` update and the `stable_snap` update use the pre-update `same_cnt`+1 comparison result in the same cycle. No extra cycle is added.

## Structure
- `keypad_pkg` holds:
  - `KP_ROWS`=4, `KP_COLS`=4, `KP_KEYS`=16, `KP_CODE_W`=4
  - a `popcount16` function returning 0, 1 or "many"
- Sub-module `keypad_debounce`:
  - Inputs: `sys_clk`, `rst`, `snap_done`, `cur_snap[15:0]`.
  - Outputs: `stable_snap[15:0]`, `stable_upd`.
  - It holds `prev_snap`, `same_cnt` and `stable_snap`.
- The top holds the divider, column counter, sampler, synchroniser and press logic.

## Test plan
All scenarios use SCAN_DIV=4, DEBOUNCE=3, a 16-cycle sweep, and a bench keypad model that pulls row r low when col c is low and key (r,c) is pressed.
- **Reset:** hold `rst` 3 cycles, then release with no keys pressed → `col_out` sequence 1110, 1101, 1011, 0111 changing every 4 cycles; `key_valid` never asserts over 20 sweeps.
- **Single press:** press key (row 2, col 1) steadily → exactly one `key_valid` pulse with `key_code`=9, about 3 sweeps after the press; `key_held`=1 until 3 sweeps after release.
- **Bounce:** toggle the key every 10 cycles for 5 sweeps, then hold → no strobe during the bounce; one strobe 3 clean sweeps after it settles.
- **Multi-key:** press (0,0) and (3,3) together → no strobe and `key_held`=0. Then release (3,3) while keeping (0,0) → still no strobe, because there was no prior all-released state.
- **Re-press:** press (1,3) → release → press (1,3) → two strobes, each with `key_code`=7.
- **Mid-scan reset:** reset while key (0,2) is held, with `col_idx`=2 → outputs return to reset values on the next cycle; `key_valid` with `key_code`=2 follows about 3 sweeps later.
